sram_arbiter: RTL and testbench

//  Shares one single-ported unified SRAM between the core's instruction-fetch port (rom_*) and

---
 rtl/sram_arbiter_pkg.sv | 16 +
 rtl/sram_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the unified-SRAM arbiter: bus width, wait-counter width and FSM encoding.
package sram_arbiter_pkg;

  localparam int REG_W = 32;
  localparam int CNT_W = 4;

  typedef logic [REG_W-1:0] reg_bus_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_D_ACC = 2'd1,
    ARB_I_ACC = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Serialises the fetch and load/store ports onto one single-ported SRAM, data port first,
// with WAIT_CYCLES extra cycles per access and a stall request back to the pipeline.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ce_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_data_i,
  output logic [31:0] data_data_o,
  input  logic        hold_i,
  output logic        stallreq_o,
  output logic        sram_ce_o,
  output logic        sram_we_o,
  output logic [3:0]  sram_sel_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_data_o,
  input  logic [31:0] sram_data_i
);

  localparam cnt_t CNT_INIT = cnt_t'(WAIT_CYCLES);

  arb_state_t state;
  cnt_t       cnt;
  logic       data_done;
  logic       inst_done;
  logic       data_pend;
  logic       inst_pend;

  assign data_pend  = data_ce_i & ~data_done;
  assign inst_pend  = inst_ce_i & ~inst_done;
  assign stallreq_o = data_pend | inst_pend;

  // NOTE: every output gets a default before the case, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    sram_ce_o   = 1'b0;
    sram_we_o   = 1'b0;
    sram_sel_o  = 4'b0000;
    sram_addr_o = '0;
    sram_data_o = '0;
    case (state)
      ARB_D_ACC: begin
        sram_ce_o   = 1'b1;
        sram_we_o   = data_we_i;
        sram_sel_o  = data_sel_i;
        sram_addr_o = data_addr_i;
        sram_data_o = data_data_i;
      end
      ARB_I_ACC: begin
        sram_ce_o   = 1'b1;
        sram_sel_o  = 4'b1111;
        sram_addr_o = inst_addr_i;
      end
      default: ;
    endcase
  end

  // NOTE: all state here uses non-blocking assignment so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      cnt         <= '0;
      data_done   <= 1'b0;
      inst_done   <= 1'b0;
      inst_data_o <= '0;
      data_data_o <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (data_pend) begin
            state <= ARB_D_ACC;
            cnt   <= CNT_INIT;
          end else if (inst_pend) begin
            state <= ARB_I_ACC;
            cnt   <= CNT_INIT;
          end
        end
        ARB_D_ACC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!data_we_i) data_data_o <= sram_data_i;
            data_done <= 1'b1;
            if (inst_pend) begin
              state <= ARB_I_ACC;
              cnt   <= CNT_INIT;
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        ARB_I_ACC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            inst_data_o <= sram_data_i;
            inst_done   <= 1'b1;
            state       <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase

      // Step release comes last so a request dropped mid-access cannot leave a stale done
      // flag that would swallow the next step's request.
      if (!stallreq_o && !hold_i) begin
        data_done <= 1'b0;
        inst_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench: three arbiters (WAIT_CYCLES 0,1,2) each with its own SRAM, checked
// cycle by cycle against a transaction-level model of one pipeline step.
module tb_sram_arbiter;

  typedef struct packed {
    logic        stall;
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk;
  logic        rst       [3];
  logic        ice       [3];
  logic [31:0] iaddr     [3];
  logic [31:0] inst_out  [3];
  logic        dce       [3];
  logic        dwe       [3];
  logic [3:0]  dsel      [3];
  logic [31:0] daddr     [3];
  logic [31:0] ddata     [3];
  logic [31:0] data_out  [3];
  logic        hold      [3];
  logic        stall     [3];
  logic        sram_ce   [3];
  logic        sram_we   [3];
  logic [3:0]  sram_sel  [3];
  logic [31:0] sram_addr [3];
  logic [31:0] sram_wdata[3];
  logic [31:0] sram_rdata[3];

  logic [31:0] sram_mem  [3][256];
  logic [31:0] mdl_mem   [3][256];
  logic [31:0] last_load [3];
  logic [31:0] last_fetch[3];

  exp_t exp_q[$];
  int   active;
  int   cyc;
  int   checks;
  int   errors;
  int   stall_seen;
  int   ce_seen;
  int   we_seen;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    sram_arbiter #(.WAIT_CYCLES(g)) dut (
      .clk        (clk),
      .rst        (rst[g]),
      .inst_ce_i  (ice[g]),
      .inst_addr_i(iaddr[g]),
      .inst_data_o(inst_out[g]),
      .data_ce_i  (dce[g]),
      .data_we_i  (dwe[g]),
      .data_sel_i (dsel[g]),
      .data_addr_i(daddr[g]),
      .data_data_i(ddata[g]),
      .data_data_o(data_out[g]),
      .hold_i     (hold[g]),
      .stallreq_o (stall[g]),
      .sram_ce_o  (sram_ce[g]),
      .sram_we_o  (sram_we[g]),
      .sram_sel_o (sram_sel[g]),
      .sram_addr_o(sram_addr[g]),
      .sram_data_o(sram_wdata[g]),
      .sram_data_i(sram_rdata[g])
    );
    assign sram_rdata[g] = sram_mem[g][sram_addr[g][9:2]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s lane=%0d cycle=%0d got=%h want=%h", name, active, cyc, act, want);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic c, input logic w, input logic [3:0] sl,
                              input logic [31:0] a, input logic [31:0] d);
    exp_t r;
    r.stall = s; r.ce = c; r.we = w; r.sel = sl; r.addr = a; r.wdata = d;
    return r;
  endfunction

  // Compare process, plus the SRAM write behaviour of every lane.
  initial begin
    exp_t r;
    int   l;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        l = active;
        check("stallreq", 32'(stall[l]), 32'(r.stall));
        check("sram_ce", 32'(sram_ce[l]), 32'(r.ce));
        if (r.ce) begin
          check("sram_we", 32'(sram_we[l]), 32'(r.we));
          check("sram_sel", 32'(sram_sel[l]), 32'(r.sel));
          check("sram_addr", sram_addr[l], r.addr);
          if (r.we) check("sram_wdata", sram_wdata[l], r.wdata);
        end else begin
          check("idle_we", 32'(sram_we[l]), 32'd0);
          check("idle_sel", 32'(sram_sel[l]), 32'd0);
        end
        if (stall[l]) stall_seen++;
        if (sram_ce[l]) ce_seen++;
        if (sram_ce[l] && sram_we[l]) we_seen++;
      end
      for (int ln = 0; ln < 3; ln++) begin
        if (sram_ce[ln] && sram_we[ln]) begin
          for (int b = 0; b < 4; b++) begin
            if (sram_sel[ln][b])
              sram_mem[ln][sram_addr[ln][9:2]][8*b +: 8] = sram_wdata[ln][8*b +: 8];
          end
        end
      end
    end
  end

  task automatic set_mem(input int l, input int idx, input logic [31:0] v);
    sram_mem[l][idx] = v;
    mdl_mem[l][idx]  = v;
  endtask

  task automatic clear_seen();
    stall_seen = 0;
    ce_seen    = 0;
    we_seen    = 0;
  endtask

  // One pipeline step: stall for IDLE + (W+1) per requested port, data first, then hold_n
  // held cycles and one release cycle.
  task automatic run_step(input int l, input bit d, input bit dw, input logic [3:0] s,
                          input logic [31:0] da, input logic [31:0] dd, input bit i,
                          input logic [31:0] ia, input int hold_n);
    int n_stall;
    int total;
    n_stall = 0;
    clear_seen();
    if (d || i) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
      n_stall++;
    end
    if (d) begin
      repeat (l + 1) exp_q.push_back(mk(1, 1, dw, s, da, dd));
      n_stall += l + 1;
      if (dw) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl_mem[l][da[9:2]][8*b +: 8] = dd[8*b +: 8];
      end else begin
        last_load[l] = mdl_mem[l][da[9:2]];
      end
    end
    if (i) begin
      repeat (l + 1) exp_q.push_back(mk(1, 1, 0, 4'hF, ia, 0));
      n_stall += l + 1;
      last_fetch[l] = mdl_mem[l][ia[9:2]];
    end
    repeat (hold_n + 1) exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    total = n_stall + hold_n + 1;
    dce[l] = d; dwe[l] = dw; dsel[l] = s; daddr[l] = da; ddata[l] = dd;
    ice[l] = i; iaddr[l] = ia;
    for (int k = 0; k < total; k++) begin
      hold[l] = (hold_n > 0) && (k < total - 1);
      @(posedge clk); #1;
    end
    dce[l] = 1'b0; ice[l] = 1'b0; hold[l] = 1'b0;
    check("data_data_o", data_out[l], last_load[l]);
    check("inst_data_o", inst_out[l], last_fetch[l]);
  endtask

  task automatic idle(input int l, input int n);
    clear_seen();
    repeat (n) exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] v;
    checks = 0; errors = 0; active = 0;
    clear_seen();
    for (int l = 0; l < 3; l++) begin
      rst[l] = 1'b1; ice[l] = 1'b0; iaddr[l] = '0; dce[l] = 1'b0; dwe[l] = 1'b0;
      dsel[l] = '0; daddr[l] = '0; ddata[l] = '0; hold[l] = 1'b0;
      last_load[l] = '0; last_fetch[l] = '0;
      for (int idx = 0; idx < 256; idx++) begin
        v = $urandom;
        set_mem(l, idx, v);
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int l = 0; l < 3; l++) rst[l] = 1'b0;
    for (int l = 0; l < 3; l++) begin
      active = l;
      check("reset_inst_data", inst_out[l], 32'd0);
      check("reset_data_data", data_out[l], 32'd0);
      check("reset_stallreq", 32'(stall[l]), 32'd0);
      check("reset_sram_ce", 32'(sram_ce[l]), 32'd0);
    end

    // W=1 fetch-only step.
    active = 1;
    set_mem(1, 32'h100 >> 2, 32'h3C010101);
    run_step(1, 0, 0, 4'h0, 0, 0, 1, 32'h100, 0);
    check("t1_stall_cycles", stall_seen, 32'd3);
    check("t1_ce_cycles", ce_seen, 32'd2);
    check("t1_inst_word", inst_out[1], 32'h3C010101);

    // W=0 load + fetch in one step, data port first.
    active = 0;
    set_mem(0, 32'h40 >> 2, 32'h11112222);
    set_mem(0, 32'h8 >> 2, 32'h33334444);
    run_step(0, 1, 0, 4'hF, 32'h40, 0, 1, 32'h8, 0);
    check("t2_stall_cycles", stall_seen, 32'd3);
    check("t2_load_word", data_out[0], 32'h11112222);
    check("t2_fetch_word", inst_out[0], 32'h33334444);

    // Held store + fetch: exactly one write cycle, then a readback of the merged word.
    set_mem(0, 32'h20 >> 2, 32'hDEAD0000);
    run_step(0, 1, 1, 4'b0011, 32'h20, 32'h0000BEEF, 1, 32'h24, 5);
    check("t3_write_cycles", we_seen, 32'd1);
    run_step(0, 1, 0, 4'hF, 32'h20, 0, 0, 0, 0);
    check("t3_readback", data_out[0], 32'hDEADBEEF);

    idle(0, 10);
    check("t5_ce_cycles", ce_seen, 32'd0);
    check("t5_stall_cycles", stall_seen, 32'd0);

    for (int k = 0; k < 3; k++) set_mem(0, k, 32'hA0000000 + 32'(k));
    for (int k = 0; k < 3; k++) begin
      run_step(0, 0, 0, 4'h0, 0, 0, 1, 32'(4 * k), 0);
      check("t6_fetch_word", inst_out[0], 32'hA0000000 + 32'(k));
    end

    // W=2: reset in the second D_ACC cycle.
    active = 2;
    set_mem(2, 32'h80 >> 2, 32'h5A5A0001);
    run_step(2, 1, 0, 4'hF, 32'h80, 0, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 4'hF, 32'h40, 0));
    exp_q.push_back(mk(1, 1, 0, 4'hF, 32'h40, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    dce[2] = 1'b1; dwe[2] = 1'b0; dsel[2] = 4'hF; daddr[2] = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0; dce[2] = 1'b0;
    check("t4_data_after_rst", data_out[2], 32'd0);
    check("t4_ce_after_rst", 32'(sram_ce[2]), 32'd0);
    @(posedge clk); #1;
    last_load[2] = '0;

    // Reset while a completed fetch is held clears its done flag, so the fetch repeats.
    set_mem(2, 5, 32'h77770005);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    repeat (3) exp_q.push_back(mk(1, 1, 0, 4'hF, 32'h14, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
    repeat (3) exp_q.push_back(mk(1, 1, 0, 4'hF, 32'h14, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    ice[2] = 1'b1; iaddr[2] = 32'h14; hold[2] = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0; hold[2] = 1'b0;
    check("t4_inst_after_rst", inst_out[2], 32'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    ice[2] = 1'b0;
    last_fetch[2] = 32'h77770005;
    check("t4_refetch_word", inst_out[2], 32'h77770005);

    // Randomised steps on every lane.
    for (int l = 0; l < 3; l++) begin
      active = l;
      repeat (60) begin
        run_step(l, 1'($urandom), 1'($urandom), 4'($urandom_range(1, 15)),
                 {22'd0, 8'($urandom), 2'd0}, $urandom, 1'($urandom),
                 {22'd0, 8'($urandom), 2'd0}, int'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
